// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, instruction-memory handshake and the IF/ID register.
// Define STAGE_IF_PERF_EN to add the fetchCount/stallCount performance counters.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        takeBranch,
  input  logic [31:0] branchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_id,
`ifdef STAGE_IF_PERF_EN
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount,
`endif
  output logic        instrValid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] buffer;
  logic [31:0] drainAddr;
  logic        loadValid;

  function automatic logic [31:0] incPc(input logic [31:0] cur);
    return cur + 32'(PC_STEP);
  endfunction

  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

  // DRAIN keeps presenting the abandoned address until memory answers it.
  always_comb begin
    imem_req  = (state == FETCH) || (state == DRAIN);
    imem_addr = (state == DRAIN) ? drainAddr : pc;
  end

  assign loadValid = !takeBranch && !stall &&
                     (((state == FETCH) && imem_valid) || (state == HOLD));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr      <= 32'h0;
      pc_id      <= 32'h0;
      instrValid <= 1'b0;
      buffer     <= 32'h0;
      drainAddr  <= 32'h0;
    end else if (takeBranch) begin
      pc         <= alignPc(branchTarget);
      instr      <= 32'h0;
      instrValid <= 1'b0;
      if (((state == FETCH) || (state == DRAIN)) && !imem_valid) begin
        state <= DRAIN;
        if (state == FETCH)
          drainAddr <= pc;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_valid && stall) begin
            buffer <= imem_rdata;
            state  <= HOLD;
          end else if (imem_valid) begin
            instr      <= imem_rdata;
            pc_id      <= incPc(pc);
            instrValid <= 1'b1;
            pc         <= incPc(pc);
          end else if (!stall) begin
            instr      <= 32'h0;
            instrValid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr      <= buffer;
            pc_id      <= incPc(pc);
            instrValid <= 1'b1;
            pc         <= incPc(pc);
            state      <= FETCH;
          end
        end
        default: begin
          if (imem_valid)
            state <= FETCH;
        end
      endcase
    end
  end

`ifdef STAGE_IF_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetchCount <= 32'h0;
      stallCount <= 32'h0;
    end else begin
      if (loadValid)
        fetchCount <= fetchCount + 32'd1;
      if (stall)
        stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: memory model with programmable wait states plus
// a second instance exercising PC wrap-around from RESET_PC = 32'hFFFF_FFFC.
module tb_stage_if;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        takeBranch;
  logic [31:0] branchTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_id;
  logic        instrValid;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] instr2;
  logic [31:0] pcId2;
  logic        valid2;
  logic        zeroBit = 1'b0;
  logic [31:0] zeroWord = 32'h0;
  logic [31:0] word2 = 32'hABCD_0000;

`ifdef STAGE_IF_PERF_EN
  logic [31:0] fetchCount, stallCount, fetchCount2, stallCount2;
`endif

  logic        memEn;
  logic        forceValid;
  int unsigned waitStates;
  int unsigned waitCnt;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  stage_if dut (
    .clock(clock), .reset(reset), .stall(stall), .takeBranch(takeBranch),
    .branchTarget(branchTarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr(instr), .pc_id(pc_id),
`ifdef STAGE_IF_PERF_EN
    .fetchCount(fetchCount), .stallCount(stallCount),
`endif
    .instrValid(instrValid)
  );

  stage_if #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clock(clock), .reset(reset), .stall(zeroBit), .takeBranch(zeroBit),
    .branchTarget(zeroWord), .imem_req(req2), .imem_addr(addr2),
    .imem_valid(req2), .imem_rdata(word2), .instr(instr2), .pc_id(pcId2),
`ifdef STAGE_IF_PERF_EN
    .fetchCount(fetchCount2), .stallCount(stallCount2),
`endif
    .instrValid(valid2)
  );

  // Memory answers after waitStates idle cycles; word value encodes its address.
  always_comb begin
    imem_valid = forceValid || (memEn && imem_req && (waitCnt >= waitStates));
    imem_rdata = 32'h2001_0005 + imem_addr;
  end

  always_ff @(posedge clock) begin
    if (imem_valid || !imem_req)
      waitCnt <= 0;
    else
      waitCnt <= waitCnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; takeBranch = 1'b0; branchTarget = 32'h0;
    memEn = 1'b0; forceValid = 1'b0; waitStates = 0;
    tick(); tick();
    check("rst_instr", instr, 32'h0);
    check("rst_pcid", pc_id, 32'h0);
    check("rst_valid", {31'b0, instrValid}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);

    reset = 1'b1; memEn = 1'b1;
    tick();
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid_low", {31'b0, instrValid}, 32'h0);
    tick();
    check("zw_instr", instr, 32'h2001_0005);
    check("zw_pcid", pc_id, 32'h4);
    check("zw_valid", {31'b0, instrValid}, 32'h1);
    check("zw_next_addr", imem_addr, 32'h4);
    check("wrap_instr", instr2, 32'hABCD_0000);
    check("wrap_pcid", pcId2, 32'h0);
    check("wrap_next_addr", addr2, 32'h0);
`ifdef STAGE_IF_PERF_EN
    check("perf_fetch", fetchCount, 32'd1);
`endif
    tick();
    check("zw2_instr", instr, 32'h2001_0009);
    check("zw2_pcid", pc_id, 32'h8);

    // Three wait states on the fetch at 0x8.
    waitStates = 3;
    for (int i = 0; i < 4; i++) begin
      check("ws_req", {31'b0, imem_req}, 32'h1);
      check("ws_addr", imem_addr, 32'h8);
      if (i > 0) check("ws_bubble", {31'b0, instrValid}, 32'h0);
      tick();
    end
    check("ws_instr", instr, 32'h2001_000D);
    check("ws_pcid", pc_id, 32'hC);
    check("ws_valid", {31'b0, instrValid}, 32'h1);

    waitStates = 0;
    tick();
    check("pre_stall_instr", instr, 32'h2001_0011);
    check("pre_stall_addr", imem_addr, 32'h10);

    // Word at 0x10 arrives under stall: parked in the buffer.
    stall = 1'b1;
    tick();
    check("hold_instr", instr, 32'h2001_0011);
    check("hold_pcid", pc_id, 32'h10);
    check("hold_req", {31'b0, imem_req}, 32'h0);
    tick();
    check("hold2_instr", instr, 32'h2001_0011);
    check("hold2_req", {31'b0, imem_req}, 32'h0);
    stall = 1'b0;
    tick();
    check("release_instr", instr, 32'h2001_0015);
    check("release_pcid", pc_id, 32'h14);
    check("release_valid", {31'b0, instrValid}, 32'h1);
    check("release_addr", imem_addr, 32'h14);

    tick(); tick(); tick();
    check("pre_br_instr", instr, 32'h2001_0021);
    check("pre_br_addr", imem_addr, 32'h20);

    // Redirect while the 0x20 fetch is still waiting.
    waitStates = 2;
    takeBranch = 1'b1; branchTarget = 32'h43;
    tick();
    takeBranch = 1'b0; branchTarget = 32'h0;
    check("br_instr", instr, 32'h0);
    check("br_valid", {31'b0, instrValid}, 32'h0);
    check("drain_addr", imem_addr, 32'h20);
    check("drain_req", {31'b0, imem_req}, 32'h1);
    tick();
    check("drain2_addr", imem_addr, 32'h20);
    check("drain2_instr", instr, 32'h0);
    tick();
    check("post_drain_addr", imem_addr, 32'h40);
    check("post_drain_instr", instr, 32'h0);
    check("post_drain_valid", {31'b0, instrValid}, 32'h0);
    waitStates = 0;
    tick();
    check("br_target_instr", instr, 32'h2001_0045);
    check("br_target_pcid", pc_id, 32'h44);

    // Reset during a pending fetch, with a stray response.
    waitStates = 3;
    reset = 1'b0; forceValid = 1'b1;
    tick();
    check("mid_rst_req", {31'b0, imem_req}, 32'h0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_pcid", pc_id, 32'h0);
    check("mid_rst_valid", {31'b0, instrValid}, 32'h0);
    tick();
    check("stray_instr", instr, 32'h0);
    check("stray_valid", {31'b0, instrValid}, 32'h0);
    reset = 1'b1; forceValid = 1'b0; waitStates = 0;
    tick();
    check("restart_addr", imem_addr, 32'h0);
    check("restart_req", {31'b0, imem_req}, 32'h1);
    tick();
    check("restart_instr", instr, 32'h2001_0005);
    check("restart_pcid", pc_id, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
